// File: rtl/seq_mul_pkg.sv
// Shared types for the sequential signed multiplier.
// State encoding and step-counter sizing.
package seq_mul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      NEGA,
      NEGB,
      MUL,
      FIX,
      DONE
   } state_t;

   localparam int SEQ_MUL_BITS = 4;
   localparam int STEP_W = $clog2(SEQ_MUL_BITS);

   // Counter width for a given operand width; never narrower than 1 bit.
   function automatic int step_w(input int bits);
      return (bits < 2) ? 1 : $clog2(bits);
   endfunction

endpackage

// File: rtl/twos_negate.sv
// Combinational W-bit two's-complement negator.
// Shared by operand magnitude and product sign fix-up.
module twos_negate #(
   parameter int W = 8
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] y
);

   assign y = ~x + W'(1);

endmodule

// File: rtl/seq_signed_mul.sv
// Sequential signed shift-add multiplier, fixed BITS+3 latency.
// Optional unsigned mode via SEQ_MUL_UNSIGNED_EN (adds Uns port).
module seq_signed_mul
   import seq_mul_pkg::*;
#(
   parameter int BITS = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [BITS-1:0]   A,
   input  logic [BITS-1:0]   B,
   input  logic              Start,
`ifdef SEQ_MUL_UNSIGNED_EN
   input  logic              Uns,
`endif
   output logic [2*BITS-1:0] P,
   output logic              Busy,
   output logic              Done
);

   localparam int PW = 2 * BITS;
   localparam int SW = step_w(BITS);

   state_t            state;
   logic [BITS-1:0]   a_q;
   logic [BITS-1:0]   b_q;
   logic              sgn;
   logic              uns_q;
   logic              uns_in;
   logic [BITS-1:0]   mcand;
   logic [BITS-1:0]   mplier;
   logic [PW-1:0]     acc;
   logic [SW-1:0]     step;
   logic [PW-1:0]     neg_in;
   logic [PW-1:0]     neg_out;
   logic [PW-1:0]     addend;

`ifdef SEQ_MUL_UNSIGNED_EN
   assign uns_in = Uns;
`else
   assign uns_in = 1'b0;
`endif

   // Only one state at a time drives the shared negator.
   always_comb begin
      neg_in = '0;
      unique case (state)
         NEGA:    neg_in = {{BITS{a_q[BITS-1]}}, a_q};
         NEGB:    neg_in = {{BITS{b_q[BITS-1]}}, b_q};
         FIX:     neg_in = acc;
         default: neg_in = '0;
      endcase
   end

   twos_negate #(.W(PW)) u_neg (
      .x (neg_in),
      .y (neg_out)
   );

   assign addend = {{BITS{1'b0}}, mcand} << step;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         sgn    <= 1'b0;
         uns_q  <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         step   <= '0;
         P      <= '0;
         Busy   <= 1'b0;
         Done   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Start) begin
                  a_q   <= A;
                  b_q   <= B;
                  uns_q <= uns_in;
                  sgn   <= (A[BITS-1] ^ B[BITS-1]) & ~uns_in;
                  Busy  <= 1'b1;
                  state <= NEGA;
               end
            end
            NEGA: begin
               mcand <= (a_q[BITS-1] & ~uns_q) ?
                        neg_out[BITS-1:0] : a_q;
               state <= NEGB;
            end
            NEGB: begin
               mplier <= (b_q[BITS-1] & ~uns_q) ?
                         neg_out[BITS-1:0] : b_q;
               acc    <= '0;
               step   <= '0;
               state  <= MUL;
            end
            MUL: begin
               if (mplier[0])
                  acc <= acc + addend;
               mplier <= mplier >> 1;
               step   <= step + SW'(1);
               if (step == SW'(BITS - 1))
                  state <= FIX;
            end
            FIX: begin
               P     <= sgn ? neg_out : acc;
               Done  <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               Done  <= 1'b0;
               Busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
